bcd_game_timer: RTL and testbench

// - Multi-digit BCD seconds timer with a start/pause/done state machine and time-multiplexed 7-segment output.
// - Generalises the single-digit 0..7 interval display to DIGITS decimal digits, with up/down mode, preset load, pause and a scanned anode bus.
// - Drives the round timer on the board display; timeout feeds game control.

---
 rtl/bcd_game_timer.sv | 258 +++++++++++++++++++++++++
 tb/tb_bcd_game_timer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_game_timer.sv
// ---------------------------------------------------------------------------
// bcd_game_timer
//   Multi-digit BCD seconds timer for the round display. A start/pause/done
//   state machine counts up (0 -> target) or down (target -> 0) one step per
//   second. The count is shown on a time-multiplexed 7-segment display.
//
// Parameters
//   CLOCK_FREQ : clk cycles per counted second
//   DIGITS     : number of BCD digits (1..4)
//   SCAN_DIV   : clk cycles each digit is shown before the scan advances
//
// Ports
//   clk     : master clock, rising edge
//   rst     : asynchronous active-high reset
//   load    : 1-cycle strobe, captures clamped preset as target and count, goes IDLE
//   preset  : BCD preset, digit 0 in [3:0]; nibbles above 9 clamp to 9
//   dir     : 1 = count up to target, 0 = count down to 0 (sampled at start)
//   start   : 1-cycle strobe, begins or restarts a run
//   pause   : level, freezes prescaler and count while in RUN
//   count   : current BCD value
//   busy    : high in RUN or PAUSE
//   timeout : 1-cycle pulse when the terminal value is reached
//   seg     : {a,b,c,d,e,f,g} active-high pattern for the digit selected by an
//   an      : one-hot active-high digit enable, an[0] = least significant digit
//
// Build option
//   TIMER_DONE_BLINK_EN : when defined, the display blinks at 2 Hz in DONE
//                         (an forced to 0 during the dark half-periods).
// ---------------------------------------------------------------------------
module bcd_game_timer #(
    parameter int CLOCK_FREQ = 50_000,
    parameter int DIGITS     = 2,
    parameter int SCAN_DIV   = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  dir,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  timeout,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int CW    = 4 * DIGITS;
    localparam int PS_W  = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam int SD_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLOCK_FREQ - 1);
    localparam logic [SD_W-1:0]  SD_LAST  = SD_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t             state;
    logic [CW-1:0]      target;
    logic               dir_q;
    logic [PS_W-1:0]    prescaler;
    logic [CW-1:0]      step_next;
    logic [CW-1:0]      terminal;

    logic [SD_W-1:0]    scan_cnt;
    logic [IDX_W-1:0]   scan_idx;
    logic               show;

    // ---------------------------------------------------------------------
    // Helper functions
    // ---------------------------------------------------------------------
    function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9)
                r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    function automatic logic [DIGITS-1:0] one_hot(input logic [IDX_W-1:0] i);
        logic [DIGITS-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    always_comb begin
        step_next = dir_q ? bcd_inc(count) : bcd_dec(count);
        terminal  = dir_q ? target : '0;
    end

    assign busy = (state == S_RUN) || (state == S_PAUSE);

    // ---------------------------------------------------------------------
    // Control state machine: load > start > pause > tick
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            target    <= '0;
            count     <= '0;
            prescaler <= '0;
            dir_q     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (load) begin
                target    <= bcd_clamp(preset);
                count     <= bcd_clamp(preset);
                prescaler <= '0;
                state     <= S_IDLE;
            end else if (start) begin
                dir_q     <= dir;
                prescaler <= '0;
                count     <= dir ? '0 : target;
                // Both directions start at their terminal when target is 0,
                // so the run is skipped and completion is signalled at once.
                if (target == '0) begin
                    state   <= S_DONE;
                    timeout <= 1'b1;
                end else begin
                    state <= S_RUN;
                end
            end else begin
                case (state)
                    S_RUN: begin
                        if (pause) begin
                            state <= S_PAUSE;
                        end else if (prescaler == PS_LAST) begin
                            prescaler <= '0;
                            count     <= step_next;
                            if (step_next == terminal) begin
                                state   <= S_DONE;
                                timeout <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + PS_W'(1);
                        end
                    end
                    S_PAUSE: begin
                        // Prescaler is held, so the interrupted second resumes.
                        if (!pause)
                            state <= S_RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Optional DONE blink: visibility flag toggles every quarter second
    // ---------------------------------------------------------------------
`ifdef TIMER_DONE_BLINK_EN
    localparam int BL_CYC = (CLOCK_FREQ / 4 > 0) ? CLOCK_FREQ / 4 : 1;
    localparam int BL_W   = (BL_CYC > 1) ? $clog2(BL_CYC) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BL_CYC - 1);

    logic [BL_W-1:0] blink_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            show      <= 1'b1;
        end else if (state != S_DONE) begin
            blink_cnt <= '0;
            show      <= 1'b1;
        end else if (blink_cnt == BL_LAST) begin
            blink_cnt <= '0;
            show      <= ~show;
        end else begin
            blink_cnt <= blink_cnt + BL_W'(1);
        end
    end
`else
    assign show = 1'b1;
`endif

    // ---------------------------------------------------------------------
    // Display scan: free-running, registered seg/an lag index/count by 1 clk
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            seg      <= '0;
            an       <= '0;
        end else begin
            seg <= seg_decode(count[4*scan_idx +: 4]);
            an  <= show ? one_hot(scan_idx) : '0;
            if (scan_cnt == SD_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_game_timer.sv
// ---------------------------------------------------------------------------
// tb_bcd_game_timer
//   Self-checking bench for bcd_game_timer (CLOCK_FREQ=8, DIGITS=2,
//   SCAN_DIV=2). A behavioural model keeps the count as a plain integer and
//   the display as digit arithmetic; every cycle the DUT outputs are compared
//   against it. Directed scenarios are followed by randomized stimulus.
// ---------------------------------------------------------------------------
module tb_bcd_game_timer;

    localparam int CF = 8;
    localparam int D  = 2;
    localparam int SD = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] preset;
    logic       dir;
    logic       start;
    logic       pause;
    logic [7:0] count;
    logic       busy;
    logic       timeout;
    logic [6:0] seg;
    logic [1:0] an;

    int n_chk  = 0;
    int n_pass = 0;
    int to_seen = 0;

    // Model state
    int m_state, m_target, m_count, m_ps, m_dir, m_to;
    int m_div, m_idx, m_seg, m_an, m_vis, m_bcnt;

    logic [6:0] pat [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011};

    bcd_game_timer #(.CLOCK_FREQ(CF), .DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .load(load), .preset(preset), .dir(dir),
        .start(start), .pause(pause), .count(count), .busy(busy),
        .timeout(timeout), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int clamp_val(input logic [7:0] p);
        int d0, d1;
        d0 = (p[3:0] > 4'd9) ? 9 : int'(p[3:0]);
        d1 = (p[7:4] > 4'd9) ? 9 : int'(p[7:4]);
        return d1 * 10 + d0;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_target = 0; m_count = 0; m_ps = 0; m_dir = 0; m_to = 0;
        m_div = 0; m_idx = 0; m_seg = 0; m_an = 0; m_vis = 1; m_bcnt = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int dig;
        dig   = (m_idx == 0) ? (m_count % 10) : (m_count / 10);
        m_seg = int'(pat[dig]);
        m_an  = m_vis ? (1 << m_idx) : 0;
`ifdef TIMER_DONE_BLINK_EN
        if (m_state != M_DONE) begin
            m_bcnt = 0; m_vis = 1;
        end else if (m_bcnt == CF / 4 - 1) begin
            m_bcnt = 0; m_vis = !m_vis;
        end else begin
            m_bcnt++;
        end
`endif
        if (m_div == SD - 1) begin
            m_div = 0;
            m_idx = (m_idx + 1) % D;
        end else begin
            m_div++;
        end

        m_to = 0;
        if (load) begin
            m_target = clamp_val(preset);
            m_count  = m_target;
            m_ps     = 0;
            m_state  = M_IDLE;
        end else if (start) begin
            m_dir   = dir;
            m_ps    = 0;
            m_count = dir ? 0 : m_target;
            if (m_target == 0) begin
                m_state = M_DONE; m_to = 1;
            end else begin
                m_state = M_RUN;
            end
        end else if (m_state == M_RUN) begin
            if (pause) begin
                m_state = M_PAUSE;
            end else if (m_ps == CF - 1) begin
                m_ps    = 0;
                m_count = m_dir ? m_count + 1 : m_count - 1;
                if (m_count == (m_dir ? m_target : 0)) begin
                    m_state = M_DONE; m_to = 1;
                end
            end else begin
                m_ps++;
            end
        end else if (m_state == M_PAUSE && !pause) begin
            m_state = M_RUN;
        end
    endtask

    task automatic compare();
        check("count", count, to_bcd(m_count));
        check("busy", busy, (m_state == M_RUN || m_state == M_PAUSE));
        check("timeout", timeout, m_to);
        check("seg", seg, m_seg);
        check("an", an, m_an);
        if (timeout) to_seen++;
    endtask

    // Called at a negedge: drive inputs, run model, clock once, compare.
    task automatic step(input logic l, input logic [7:0] p, input logic d,
                        input logic s, input logic pa);
        load = l; preset = p; dir = d; start = s; pause = pa;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n, input logic pa);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, pa);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_count"}, count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_seg"}, seg, 0);
        check({tag, "_an"}, an, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic pa_r;
        logic [7:0] p_r;
        rst = 1'b0; load = 1'b0; preset = 8'h00; dir = 1'b0; start = 1'b0; pause = 1'b0;
        do_reset("rst0");

        // Count down from 12 with BCD borrow
        to_seen = 0;
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && m_state != M_DONE; i++) idle(1, 1'b0);
        check("down_done_count", count, 8'h00);
        idle(5, 1'b0);
        check("down_timeout_pulses", to_seen, 1);

        // Count up to 03 with a 20-cycle pause at 01
        to_seen = 0;
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && m_count != 1; i++) idle(1, 1'b0);
        idle(20, 1'b1);
        check("pause_count", count, 8'h01);
        check("pause_busy", busy, 1);
        for (int i = 0; i < 60 && m_state != M_DONE; i++) idle(1, 1'b0);
        check("up_done_count", count, 8'h03);
        idle(3, 1'b0);
        check("up_timeout_pulses", to_seen, 1);

        // Start with target 0: immediate DONE
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("zero_timeout", timeout, 1);
        check("zero_busy", busy, 0);
        idle(3, 1'b0);

        // load+start same cycle with clamped preset
        step(1'b1, 8'hA7, 1'b0, 1'b1, 1'b0);
        check("clamp_count", count, 8'h97);
        check("clamp_busy", busy, 0);
        idle(8, 1'b0);

        // Async reset mid-run at count 05
        step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 60 && m_count != 5; i++) idle(1, 1'b0);
        check("pre_rst_count", count, 8'h05);
        to_seen = 0;
        do_reset("rst_mid");
        idle(8, 1'b0);
        check("rst_no_timeout", to_seen, 0);

        // Randomized stimulus
        pa_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) pa_r = ~pa_r;
            if ($urandom_range(0, 3) == 0) p_r = 8'($urandom);
            else p_r = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 1499) == 0) do_reset("rst_rand");
            else step(($urandom_range(0, 63) == 0), p_r, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 39) == 0), pa_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
